qspi_img_sched: RTL and testbench
=================================

QSPI_IMG_SCHED -- requirements
Module: qspi_img_sched

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- SWITCH_GAP, 8, cycles start is held low between images.
- PRIME_TIMEOUT, 65535, max clk cycles allowed in PRIME.
REQ-002 Reset SHALL be reset_n, asynchronous, active-low; clock SHALL be clk.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  input  1  system clock.
- reset_n  input  1  async active-low reset.
- enable  input  1  level; 1 runs the scheduler, 0 forces IDLE.
- frame_hold  input  8  frames per image; 0 means never advance.
- img_count  input  4  number of stored images; 0 is treated as 1.
- frame_done  input  1  one-cycle pulse at end of each displayed frame.
- fifo_rdy  input  1  reader FIFO holds at least one full line.
- underflow  input  1  one-cycle pulse on pixel FIFO underrun.
- start  output  1  level start to the QSPI line reader.
- img_id  output  4  image select to the reader.
- disp_en  output  1  enables the pixel timing generator.
- state  output  3  FSM state.
- err_cnt  output  8  underflow count, saturating.
- timeout_err  output  1  sticky prime timeout flag.

Function
REQ-004 The FSM SHALL have states IDLE=0, PRIME=1, RUN=2, SWITCH=3, ERROR=4; all outputs SHALL be registered.
REQ-005 IDLE: start=0, disp_en=0; enable=1 SHALL move to PRIME on the next clk edge.
REQ-006 PRIME: start=1, disp_en=0; fifo_rdy=1 SHALL move to RUN, with disp_en=1 from the first RUN cycle.
REQ-007 RUN: start=1, disp_en=1; each frame_done SHALL increment frame_cnt (8 bit).
REQ-008 RUN, frame_done with frame_hold!=0 and frame_cnt==frame_hold-1: SHALL go to SWITCH, clear frame_cnt, and set advance=1.
REQ-009 frame_hold==0: frame_cnt SHALL wrap freely and no advance SHALL occur.
REQ-010 RUN, underflow: SHALL go to SWITCH with advance=0 (restart the same image), clear frame_cnt, and increment err_cnt, saturating at 255.
REQ-011 underflow and frame_done in the same cycle: underflow SHALL win; that frame SHALL not be counted.
REQ-012 SWITCH: start=0 and disp_en=0 for exactly SWITCH_GAP cycles, then PRIME.
REQ-013 On SWITCH entry with advance=1: img_id SHALL become img_id+1, wrapping to 0 when img_id>=eff_count-1 (eff_count = max(img_count,1)).
REQ-014 enable=0 in any state SHALL force IDLE on the next edge: start=0, disp_en=0, frame_cnt=0; img_id and err_cnt SHALL be retained.
REQ-015 enable=0 SHALL take priority over all other events in the same cycle.
REQ-016 fifo_rdy dropping in RUN SHALL NOT by itself change state; only underflow is acted on.
REQ-017 img_count changed while running SHALL take effect at the next advance; an img_id out of range SHALL wrap to 0 at that advance.

Reset
REQ-018 reset_n=0 SHALL asynchronously set state=IDLE, start=0, disp_en=0, img_id=0, frame_cnt=0, err_cnt=0, timeout_err=0, gap counter=0, and the PRIME cycle counter=0.
REQ-019 Reset mid-PRIME or mid-SWITCH SHALL abort immediately; after release, operation SHALL restart from IDLE.

Configuration
REQ-020 With macro QSPI_SCHED_TIMEOUT_EN defined:
- A 16-bit counter SHALL run in PRIME.
- Exceeding PRIME_TIMEOUT cycles without fifo_rdy SHALL move to ERROR: start=0, disp_en=0, timeout_err=1.
- ERROR SHALL exit only via enable=0, which returns to IDLE and clears timeout_err.
REQ-021 Without QSPI_SCHED_TIMEOUT_EN: PRIME SHALL wait indefinitely, ERROR SHALL be unreachable, and timeout_err SHALL be constant 0.

Verification
REQ-022 Power-up: reset, then enable=1, then fifo_rdy=1 after 100 cycles -> state 0->1->2; start=1 one cycle after enable; disp_en=1 one cycle after fifo_rdy.
REQ-023 Advance with wrap: frame_hold=2, img_count=3, 7 frame_done pulses, fifo_rdy held 1 -> img_id sequence 0,1,2,0; start low for exactly 8 cycles at each switch.
REQ-024 Underflow: RUN, img_id=1, underflow pulse coincident with frame_done -> SWITCH, img_id stays 1, err_cnt=1; 300 underflows -> err_cnt=255.
REQ-025 Abort: enable=0 during SWITCH gap cycle 3 -> IDLE next cycle, start=0, img_id retained; re-enable -> PRIME.
REQ-026 Timeout (macro on, PRIME_TIMEOUT=50): fifo_rdy held 0 -> ERROR after 51 PRIME cycles, timeout_err=1; enable=0 -> IDLE and timeout_err=0. Macro off: state stays 1 after 1000 cycles.
REQ-027 frame_hold=0 with 600 frame_done pulses -> img_id stays 0 and state stays RUN.

Source files
------------

// File: rtl/qspi_img_sched.sv
// Image-rotation scheduler for a QSPI-fed display: primes the line reader, runs frames,
// rotates images with a start gap. Optional PRIME watchdog under QSPI_SCHED_TIMEOUT_EN.
module qspi_img_sched #(
    parameter int SWITCH_GAP    = 8,
    parameter int PRIME_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] frame_hold,
    input  logic [3:0] img_count,
    input  logic       frame_done,
    input  logic       fifo_rdy,
    input  logic       underflow,
    output logic       start,
    output logic [3:0] img_id,
    output logic       disp_en,
    output logic [2:0] state,
    output logic [7:0] err_cnt,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRIME  = 3'd1,
        RUN    = 3'd2,
        SWITCH = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam int GW = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(SWITCH_GAP - 1);

    state_t        cur, nxt;
    logic [7:0]    frame_cnt, frame_nxt, err_nxt;
    logic [3:0]    img_nxt, img_last;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          start_nxt, disp_nxt;

`ifdef QSPI_SCHED_TIMEOUT_EN
    logic [15:0] prime_cnt, prime_nxt;
    logic        tout_nxt;
`else
    logic unused_prime_timeout;
    assign unused_prime_timeout = |16'(PRIME_TIMEOUT);
    assign timeout_err = 1'b0;
`endif

    // img_count of 0 behaves as a single image, so the last valid id is 0
    assign img_last = (img_count == 4'd0) ? 4'd0 : img_count - 4'd1;
    assign state    = cur;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur       <= IDLE;
            start     <= 1'b0;
            disp_en   <= 1'b0;
            img_id    <= 4'd0;
            frame_cnt <= 8'd0;
            err_cnt   <= 8'd0;
            gap_cnt   <= '0;
`ifdef QSPI_SCHED_TIMEOUT_EN
            prime_cnt   <= 16'd0;
            timeout_err <= 1'b0;
`endif
        end else begin
            cur       <= nxt;
            start     <= start_nxt;
            disp_en   <= disp_nxt;
            img_id    <= img_nxt;
            frame_cnt <= frame_nxt;
            err_cnt   <= err_nxt;
            gap_cnt   <= gap_nxt;
`ifdef QSPI_SCHED_TIMEOUT_EN
            prime_cnt   <= prime_nxt;
            timeout_err <= tout_nxt;
`endif
        end
    end

    always_comb begin
        nxt       = cur;
        frame_nxt = frame_cnt;
        err_nxt   = err_cnt;
        img_nxt   = img_id;
        gap_nxt   = gap_cnt;
`ifdef QSPI_SCHED_TIMEOUT_EN
        prime_nxt = prime_cnt;
        tout_nxt  = timeout_err;
`endif
        if (!enable) begin
            nxt       = IDLE;
            frame_nxt = 8'd0;
            gap_nxt   = '0;
`ifdef QSPI_SCHED_TIMEOUT_EN
            prime_nxt = 16'd0;
            tout_nxt  = 1'b0;
`endif
        end else begin
            case (cur)
                IDLE: begin
                    nxt = PRIME;
`ifdef QSPI_SCHED_TIMEOUT_EN
                    prime_nxt = 16'd0;
`endif
                end
                PRIME: begin
                    if (fifo_rdy) begin
                        nxt = RUN;
`ifdef QSPI_SCHED_TIMEOUT_EN
                        prime_nxt = 16'd0;
                    end else if (prime_cnt == 16'(PRIME_TIMEOUT)) begin
                        nxt      = ERROR;
                        tout_nxt = 1'b1;
                    end else begin
                        prime_nxt = prime_cnt + 16'd1;
`endif
                    end
                end
                RUN: begin
                    // underflow outranks frame_done: the frame in flight is discarded
                    if (underflow) begin
                        nxt       = SWITCH;
                        frame_nxt = 8'd0;
                        gap_nxt   = '0;
                        if (err_cnt != 8'hFF) err_nxt = err_cnt + 8'd1;
                    end else if (frame_done) begin
                        if (frame_hold != 8'd0 && frame_cnt == frame_hold - 8'd1) begin
                            nxt       = SWITCH;
                            frame_nxt = 8'd0;
                            gap_nxt   = '0;
                            img_nxt   = (img_id >= img_last) ? 4'd0 : img_id + 4'd1;
                        end else begin
                            frame_nxt = frame_cnt + 8'd1;
                        end
                    end
                end
                SWITCH: begin
                    if (gap_cnt == GAP_LAST) begin
                        nxt     = PRIME;
                        gap_nxt = '0;
                    end else begin
                        gap_nxt = gap_cnt + 1'b1;
                    end
                end
                ERROR:   nxt = ERROR;
                default: nxt = IDLE;
            endcase
        end
        start_nxt = (nxt == PRIME) || (nxt == RUN);
        disp_nxt  = (nxt == RUN);
    end

endmodule

// File: tb/tb_qspi_img_sched.sv
// Directed bench for qspi_img_sched: power-up, rotation, underflow, abort, disable,
// img_count edge cases, hold=0, PRIME timeout (either build) and async reset aborts.
module tb_qspi_img_sched;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] frame_hold = 8'd2;
    logic [3:0] img_count = 4'd3;
    logic       frame_done = 1'b0;
    logic       fifo_rdy = 1'b0;
    logic       underflow = 1'b0;
    logic       start;
    logic [3:0] img_id;
    logic       disp_en;
    logic [2:0] state;
    logic [7:0] err_cnt;
    logic       timeout_err;

    int vectors = 0;
    int fails = 0;

    qspi_img_sched #(.SWITCH_GAP(8), .PRIME_TIMEOUT(50)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .frame_hold(frame_hold),
        .img_count(img_count), .frame_done(frame_done), .fifo_rdy(fifo_rdy),
        .underflow(underflow), .start(start), .img_id(img_id), .disp_en(disp_en),
        .state(state), .err_cnt(err_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (state !== 3'd2 && n < 40) begin
            step();
            n++;
        end
        if (state !== 3'd2) begin
            vectors++;
            fails++;
            $display("FAIL wait_run: state %0d, expected 2 within 40 cycles", state);
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (state !== 3'd0 || start !== 1'b0 || disp_en !== 1'b0) begin
            fails++; $display("FAIL reset_ctl: state=%0d start=%b disp_en=%b, want 0/0/0", state, start, disp_en);
        end
        vectors++;
        if (img_id !== 4'd0 || err_cnt !== 8'd0 || timeout_err !== 1'b0) begin
            fails++; $display("FAIL reset_regs: img_id=%0d err_cnt=%0d timeout_err=%b, want 0/0/0", img_id, err_cnt, timeout_err);
        end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_power_up();
        enable = 1'b1;
        step();
        vectors++;
        if (state !== 3'd1 || start !== 1'b1 || disp_en !== 1'b0) begin
            fails++; $display("FAIL pu_prime: state=%0d start=%b disp_en=%b, want 1/1/0", state, start, disp_en);
        end
        repeat (99) step();
        vectors++;
        if (state !== 3'd1) begin
            fails++; $display("FAIL pu_wait: state=%0d, want 1", state);
        end
        fifo_rdy = 1'b1;
        step();
        vectors++;
        if (state !== 3'd2 || start !== 1'b1 || disp_en !== 1'b1) begin
            fails++; $display("FAIL pu_run: state=%0d start=%b disp_en=%b, want 2/1/1", state, start, disp_en);
        end
    endtask

    task automatic test_advance();
        logic [3:0] exp_ids [3] = '{4'd1, 4'd2, 4'd0};
        int low;
        for (int s = 0; s < 3; s++) begin
            pulse_frame();
            vectors++;
            if (state !== 3'd2) begin
                fails++; $display("FAIL adv_hold%0d: state=%0d, want 2", s, state);
            end
            pulse_frame();
            vectors++;
            if (state !== 3'd3 || img_id !== exp_ids[s]) begin
                fails++; $display("FAIL adv_switch%0d: state=%0d img_id=%0d, want 3/%0d", s, state, img_id, exp_ids[s]);
            end
            low = (start === 1'b0) ? 1 : 0;
            for (int k = 0; k < 40 && start === 1'b0; k++) begin
                step();
                if (start === 1'b0) low++;
            end
            vectors++;
            if (low != 8) begin
                fails++; $display("FAIL adv_gap%0d: start low %0d cycles, want 8", s, low);
            end
            wait_run();
        end
        pulse_frame();
        vectors++;
        if (state !== 3'd2 || img_id !== 4'd0) begin
            fails++; $display("FAIL adv_seventh: state=%0d img_id=%0d, want 2/0", state, img_id);
        end
    endtask

    task automatic test_underflow();
        pulse_frame();
        vectors++;
        if (img_id !== 4'd1) begin
            fails++; $display("FAIL uf_setup: img_id=%0d, want 1", img_id);
        end
        wait_run();
        underflow = 1'b1;
        frame_done = 1'b1;
        step();
        underflow = 1'b0;
        frame_done = 1'b0;
        vectors++;
        if (state !== 3'd3 || img_id !== 4'd1 || err_cnt !== 8'd1) begin
            fails++; $display("FAIL uf_coincident: state=%0d img_id=%0d err_cnt=%0d, want 3/1/1", state, img_id, err_cnt);
        end
        wait_run();
        pulse_frame();
        vectors++;
        if (state !== 3'd2) begin
            fails++; $display("FAIL uf_cnt_cleared: state=%0d, want 2", state);
        end
        for (int i = 2; i <= 300; i++) begin
            underflow = 1'b1;
            step();
            underflow = 1'b0;
            if (i == 254) begin
                vectors++;
                if (err_cnt !== 8'd254) begin
                    fails++; $display("FAIL uf_254: err_cnt=%0d, want 254", err_cnt);
                end
            end
            wait_run();
        end
        vectors++;
        if (err_cnt !== 8'd255 || img_id !== 4'd1) begin
            fails++; $display("FAIL uf_saturate: err_cnt=%0d img_id=%0d, want 255/1", err_cnt, img_id);
        end
    endtask

    task automatic test_abort();
        frame_hold = 8'd1;
        pulse_frame();
        vectors++;
        if (state !== 3'd3 || img_id !== 4'd2) begin
            fails++; $display("FAIL ab_switch: state=%0d img_id=%0d, want 3/2", state, img_id);
        end
        step();
        step();
        enable = 1'b0;
        step();
        vectors++;
        if (state !== 3'd0 || start !== 1'b0 || disp_en !== 1'b0 || img_id !== 4'd2 || err_cnt !== 8'd255) begin
            fails++; $display("FAIL ab_idle: state=%0d start=%b disp_en=%b img_id=%0d err_cnt=%0d, want 0/0/0/2/255",
                              state, start, disp_en, img_id, err_cnt);
        end
        enable = 1'b1;
        step();
        vectors++;
        if (state !== 3'd1 || start !== 1'b1) begin
            fails++; $display("FAIL ab_reprime: state=%0d start=%b, want 1/1", state, start);
        end
        wait_run();
        frame_hold = 8'd2;
    endtask

    task automatic test_disable();
        pulse_frame();
        enable = 1'b0;
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        vectors++;
        if (state !== 3'd0 || img_id !== 4'd2) begin
            fails++; $display("FAIL dis_priority: state=%0d img_id=%0d, want 0/2", state, img_id);
        end
        enable = 1'b1;
        wait_run();
        pulse_frame();
        vectors++;
        if (state !== 3'd2 || img_id !== 4'd2) begin
            fails++; $display("FAIL dis_cnt_cleared: state=%0d img_id=%0d, want 2/2", state, img_id);
        end
        fifo_rdy = 1'b0;
        repeat (5) step();
        vectors++;
        if (state !== 3'd2 || disp_en !== 1'b1) begin
            fails++; $display("FAIL fifo_drop: state=%0d disp_en=%b, want 2/1", state, disp_en);
        end
        fifo_rdy = 1'b1;
    endtask

    task automatic test_img_count();
        img_count = 4'd2;
        pulse_frame();
        vectors++;
        if (state !== 3'd3 || img_id !== 4'd0) begin
            fails++; $display("FAIL cnt_shrink: state=%0d img_id=%0d, want 3/0", state, img_id);
        end
        wait_run();
        img_count = 4'd0;
        pulse_frame();
        pulse_frame();
        vectors++;
        if (state !== 3'd3 || img_id !== 4'd0) begin
            fails++; $display("FAIL cnt_zero: state=%0d img_id=%0d, want 3/0", state, img_id);
        end
        wait_run();
        img_count = 4'd3;
    endtask

    task automatic test_hold_zero();
        frame_hold = 8'd0;
        for (int i = 0; i < 600; i++) begin
            pulse_frame();
            step();
        end
        vectors++;
        if (state !== 3'd2 || img_id !== 4'd0) begin
            fails++; $display("FAIL hold_zero: state=%0d img_id=%0d, want 2/0", state, img_id);
        end
        frame_hold = 8'd2;
    endtask

    task automatic test_timeout();
        enable = 1'b0;
        fifo_rdy = 1'b0;
        step();
        enable = 1'b1;
        step();
        vectors++;
        if (state !== 3'd1) begin
            fails++; $display("FAIL to_prime: state=%0d, want 1", state);
        end
`ifdef QSPI_SCHED_TIMEOUT_EN
        repeat (50) step();
        vectors++;
        if (state !== 3'd1 || timeout_err !== 1'b0) begin
            fails++; $display("FAIL to_cycle51: state=%0d timeout_err=%b, want 1/0", state, timeout_err);
        end
        step();
        vectors++;
        if (state !== 3'd4 || timeout_err !== 1'b1 || start !== 1'b0 || disp_en !== 1'b0) begin
            fails++; $display("FAIL to_error: state=%0d timeout_err=%b start=%b disp_en=%b, want 4/1/0/0",
                              state, timeout_err, start, disp_en);
        end
        enable = 1'b0;
        step();
        vectors++;
        if (state !== 3'd0 || timeout_err !== 1'b0) begin
            fails++; $display("FAIL to_clear: state=%0d timeout_err=%b, want 0/0", state, timeout_err);
        end
`else
        repeat (1000) step();
        vectors++;
        if (state !== 3'd1 || timeout_err !== 1'b0 || start !== 1'b1) begin
            fails++; $display("FAIL to_none: state=%0d timeout_err=%b start=%b, want 1/0/1", state, timeout_err, start);
        end
`endif
    endtask

    task automatic test_reset_abort();
        enable = 1'b1;
        fifo_rdy = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0 || start !== 1'b0) begin
            fails++; $display("FAIL rst_prime: state=%0d start=%b, want 0/0", state, start);
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if (state !== 3'd1) begin
            fails++; $display("FAIL rst_restart: state=%0d, want 1", state);
        end
        fifo_rdy = 1'b1;
        wait_run();
        frame_hold = 8'd1;
        underflow = 1'b1;
        step();
        underflow = 1'b0;
        wait_run();
        pulse_frame();
        vectors++;
        if (state !== 3'd3 || img_id !== 4'd1 || err_cnt !== 8'd1) begin
            fails++; $display("FAIL rst_setup: state=%0d img_id=%0d err_cnt=%0d, want 3/1/1", state, img_id, err_cnt);
        end
        step();
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0 || img_id !== 4'd0 || err_cnt !== 8'd0 || disp_en !== 1'b0) begin
            fails++; $display("FAIL rst_switch: state=%0d img_id=%0d err_cnt=%0d disp_en=%b, want 0/0/0/0",
                              state, img_id, err_cnt, disp_en);
        end
        reset_n = 1'b1;
        step();
        vectors++;
        if (state !== 3'd1 || start !== 1'b1) begin
            fails++; $display("FAIL rst_restart2: state=%0d start=%b, want 1/1", state, start);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_advance();
        test_underflow();
        test_abort();
        test_disable();
        test_img_count();
        test_hold_zero();
        test_timeout();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
